issue_scheduler: RTL and testbench

//  In-order dual-issue scheduler between decode and the execution units (ALU, SFT, BU, LSU).

---
 rtl/issue_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_issue_scheduler.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scheduler.sv
// In-order dual-issue scheduler: circular decode queue, busy-bit scoreboard and
// per-unit valid/ready issue ports for ALU, SFT, BU and LSU.
module issue_scheduler #(
   parameter int FRONTEND_WIDTH = 2,
   parameter int QUEUE_DEPTH    = 8,
   parameter int PAYLOAD_W      = 64
) (
   input  logic                                      clk,
   input  logic                                      reset_n,
   input  logic [FRONTEND_WIDTH-1:0]                 dec_valid_i,
   output logic                                      dec_ready_o,
   input  logic [FRONTEND_WIDTH-1:0][5:0]            dec_unit_i,
   input  logic [FRONTEND_WIDTH-1:0][5:0]            dec_op_i,
   input  logic [FRONTEND_WIDTH-1:0][4:0]            dec_rs1_i,
   input  logic [FRONTEND_WIDTH-1:0][4:0]            dec_rs2_i,
   input  logic [FRONTEND_WIDTH-1:0][1:0]            dec_rs_use_i,
   input  logic [FRONTEND_WIDTH-1:0][4:0]            dec_rd_i,
   input  logic [FRONTEND_WIDTH-1:0]                 dec_rd_we_i,
   input  logic [FRONTEND_WIDTH-1:0][PAYLOAD_W-1:0]  dec_payload_i,
   output logic [3:0]                                iss_valid_o,
   input  logic [3:0]                                iss_ready_i,
   output logic [3:0][5:0]                           iss_op_o,
   output logic [3:0][4:0]                           iss_rs1_o,
   output logic [3:0][4:0]                           iss_rs2_o,
   output logic [3:0][4:0]                           iss_rd_o,
   output logic [3:0][PAYLOAD_W-1:0]                 iss_payload_o,
   input  logic [1:0]                                wb_valid_i,
   input  logic [1:0][4:0]                           wb_rd_i,
   input  logic                                      flush_i,
   output logic                                      sb_stall_o,
   output logic                                      queue_empty_o
);

   localparam int AW = $clog2(QUEUE_DEPTH);

   typedef struct packed {
      logic [1:0]           unit;
      logic [5:0]           op;
      logic [4:0]           rs1;
      logic [4:0]           rs2;
      logic [1:0]           rs_use;
      logic [4:0]           rd;
      logic                 rd_we;
      logic [PAYLOAD_W-1:0] payload;
   } entry_t;

   entry_t        queue [QUEUE_DEPTH];
   logic [AW:0]   head, tail, head1, count, free, deq, enq_cnt;
   logic [31:0]   busy, busy_next;
   entry_t        e0, e1;
   logic          empty, live, elig0, elig1, v0, v1, fire0, fire1;
   logic          enq0, enq1;

   function automatic logic reg_busy(input logic [31:0] b, input logic [4:0] r);
      return (r != 5'd0) && b[r];
   endfunction

   function automatic logic eligible(input entry_t e, input logic [31:0] b);
      return !(e.rs_use[0] && reg_busy(b, e.rs1)) &&
             !(e.rs_use[1] && reg_busy(b, e.rs2)) &&
             !(e.rd_we && reg_busy(b, e.rd));
   endfunction

   // E1 may not read or overwrite the register the older instr is about to write.
   function automatic logic pair_hazard(input entry_t a, input entry_t b);
      return a.rd_we && (a.rd != 5'd0) &&
             ((b.rs_use[0] && (b.rs1 == a.rd)) ||
              (b.rs_use[1] && (b.rs2 == a.rd)) ||
              (b.rd == a.rd));
   endfunction

   function automatic entry_t make_entry(input int s,
                                         input logic [FRONTEND_WIDTH-1:0][5:0] unit,
                                         input logic [FRONTEND_WIDTH-1:0][5:0] op,
                                         input logic [FRONTEND_WIDTH-1:0][4:0] rs1,
                                         input logic [FRONTEND_WIDTH-1:0][4:0] rs2,
                                         input logic [FRONTEND_WIDTH-1:0][1:0] rs_use,
                                         input logic [FRONTEND_WIDTH-1:0][4:0] rd,
                                         input logic [FRONTEND_WIDTH-1:0] rd_we,
                                         input logic [FRONTEND_WIDTH-1:0][PAYLOAD_W-1:0] payload);
      entry_t e;
      e.unit    = unit[s][1:0];
      e.op      = op[s];
      e.rs1     = rs1[s];
      e.rs2     = rs2[s];
      e.rs_use  = rs_use[s];
      e.rd      = rd[s];
      e.rd_we   = rd_we[s];
      e.payload = payload[s];
      return e;
   endfunction

   assign empty         = (head == tail);
   assign count         = tail - head;
   assign free          = (AW+1)'(QUEUE_DEPTH) - count;
   assign head1         = head + {{AW{1'b0}}, 1'b1};
   assign e0            = queue[head[AW-1:0]];
   assign e1            = queue[head1[AW-1:0]];
   assign live          = reset_n & ~flush_i;
   assign queue_empty_o = empty;

   assign dec_ready_o = live & (free >= (AW+1)'(2));
   assign enq0        = dec_ready_o & dec_valid_i[0];
   assign enq1        = enq0 & dec_valid_i[1];
   assign enq_cnt     = {{AW{1'b0}}, enq0} + {{AW{1'b0}}, enq1};

   assign elig0      = eligible(e0, busy);
   assign elig1      = eligible(e1, busy);
   assign v0         = live & ~empty & elig0;
   assign fire0      = v0 & iss_ready_i[e0.unit];
   assign v1         = fire0 & (count >= (AW+1)'(2)) & (e1.unit != e0.unit) &
                       elig1 & ~pair_hazard(e0, e1);
   assign fire1      = v1 & iss_ready_i[e1.unit];
   assign deq        = {{AW{1'b0}}, fire0} + {{AW{1'b0}}, fire1};
   assign sb_stall_o = live & ~empty & ~elig0;

   always_comb begin
      iss_valid_o   = '0;
      iss_op_o      = '0;
      iss_rs1_o     = '0;
      iss_rs2_o     = '0;
      iss_rd_o      = '0;
      iss_payload_o = '0;
      for (int u = 0; u < 4; u++) begin
         if (v1 && (e1.unit == 2'(u))) begin
            iss_valid_o[u]   = 1'b1;
            iss_op_o[u]      = e1.op;
            iss_rs1_o[u]     = e1.rs1;
            iss_rs2_o[u]     = e1.rs2;
            iss_rd_o[u]      = e1.rd;
            iss_payload_o[u] = e1.payload;
         end else if (e0.unit == 2'(u)) begin
            iss_valid_o[u]   = v0;
            iss_op_o[u]      = e0.op;
            iss_rs1_o[u]     = e0.rs1;
            iss_rs2_o[u]     = e0.rs2;
            iss_rd_o[u]      = e0.rd;
            iss_payload_o[u] = e0.payload;
         end
      end
   end

   // Issue sets are applied after writeback clears so a set wins on the same rd.
   always_comb begin
      busy_next = busy;
      for (int w = 0; w < 2; w++) begin
         if (wb_valid_i[w]) busy_next[wb_rd_i[w]] = 1'b0;
      end
      if (fire0 && e0.rd_we) busy_next[e0.rd] = 1'b1;
      if (fire1 && e1.rd_we) busy_next[e1.rd] = 1'b1;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         head <= '0;
         tail <= '0;
         busy <= '0;
      end else begin
         busy <= busy_next;
         if (flush_i) begin
            head <= tail;
         end else begin
            head <= head + deq;
            tail <= tail + enq_cnt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (enq0) queue[tail[AW-1:0]] <= make_entry(0, dec_unit_i, dec_op_i, dec_rs1_i,
                                                  dec_rs2_i, dec_rs_use_i, dec_rd_i,
                                                  dec_rd_we_i, dec_payload_i);
      if (enq1) queue[tail[AW-1:0] + AW'(1)] <= make_entry(1, dec_unit_i, dec_op_i, dec_rs1_i,
                                                           dec_rs2_i, dec_rs_use_i, dec_rd_i,
                                                           dec_rd_we_i, dec_payload_i);
   end

   a_slot_order: assert property (@(posedge clk) disable iff (!reset_n)
      dec_valid_i != 2'b10);
   a_unit0: assert property (@(posedge clk) disable iff (!reset_n)
      dec_valid_i[0] |-> (dec_unit_i[0] < 6'd4));
   a_unit1: assert property (@(posedge clk) disable iff (!reset_n)
      dec_valid_i[1] |-> (dec_unit_i[1] < 6'd4));

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed table-driven bench for issue_scheduler, plus a queue wrap/backpressure sequence.
module tb_issue_scheduler;

   localparam int PW = 64;
   localparam logic [PW-1:0] PTAG = 64'hC0DE_0000_0000_0000;

   logic                clk = 1'b0;
   logic                reset_n;
   logic [1:0]          dec_valid;
   logic                dec_ready;
   logic [1:0][5:0]     dec_unit, dec_op;
   logic [1:0][4:0]     dec_rs1, dec_rs2, dec_rd;
   logic [1:0][1:0]     dec_rs_use;
   logic [1:0]          dec_rd_we;
   logic [1:0][PW-1:0]  dec_payload;
   logic [3:0]          iss_valid, iss_ready;
   logic [3:0][5:0]     iss_op;
   logic [3:0][4:0]     iss_rs1, iss_rs2, iss_rd;
   logic [3:0][PW-1:0]  iss_payload;
   logic [1:0]          wb_valid;
   logic [1:0][4:0]     wb_rd;
   logic                flush, sb_stall, queue_empty;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   issue_scheduler #(.FRONTEND_WIDTH(2), .QUEUE_DEPTH(8), .PAYLOAD_W(PW)) dut (
      .clk(clk), .reset_n(reset_n),
      .dec_valid_i(dec_valid), .dec_ready_o(dec_ready),
      .dec_unit_i(dec_unit), .dec_op_i(dec_op), .dec_rs1_i(dec_rs1), .dec_rs2_i(dec_rs2),
      .dec_rs_use_i(dec_rs_use), .dec_rd_i(dec_rd), .dec_rd_we_i(dec_rd_we),
      .dec_payload_i(dec_payload),
      .iss_valid_o(iss_valid), .iss_ready_i(iss_ready), .iss_op_o(iss_op),
      .iss_rs1_o(iss_rs1), .iss_rs2_o(iss_rs2), .iss_rd_o(iss_rd),
      .iss_payload_o(iss_payload),
      .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .flush_i(flush),
      .sb_stall_o(sb_stall), .queue_empty_o(queue_empty)
   );

   typedef struct packed {
      logic [1:0] unit;
      logic [5:0] op;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [1:0] rsu;
      logic [4:0] rd;
      logic       we;
   } instr_t;

   typedef struct packed {
      logic [1:0]      dv;
      instr_t          i0;
      instr_t          i1;
      logic [3:0]      rdy;
      logic [1:0]      wbv;
      logic [4:0]      wbrd;
      logic            fl;
      logic            e_drdy;
      logic [3:0]      e_vld;
      logic            e_stall;
      logic            e_empty;
      logic [3:0][5:0] e_op;
   } vec_t;

   vec_t tv[$];

   function automatic instr_t I(input logic [1:0] u, input logic [5:0] op, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [1:0] rsu,
                                input logic [4:0] rd, input logic we);
      instr_t x;
      x.unit = u; x.op = op; x.rs1 = rs1; x.rs2 = rs2; x.rsu = rsu; x.rd = rd; x.we = we;
      return x;
   endfunction

   function automatic vec_t V(input logic [1:0] dv, input instr_t i0, input instr_t i1,
                              input logic [3:0] rdy, input logic [1:0] wbv, input logic [4:0] wbrd,
                              input logic fl, input logic drdy, input logic [3:0] vld,
                              input logic stall, input logic empty, input logic [23:0] eop);
      vec_t t;
      t.dv = dv; t.i0 = i0; t.i1 = i1; t.rdy = rdy; t.wbv = wbv; t.wbrd = wbrd; t.fl = fl;
      t.e_drdy = drdy; t.e_vld = vld; t.e_stall = stall; t.e_empty = empty; t.e_op = eop;
      return t;
   endfunction

   function automatic logic [23:0] E(input logic [5:0] o3, input logic [5:0] o2,
                                     input logic [5:0] o1, input logic [5:0] o0);
      return {o3, o2, o1, o0};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic set_slot(input int s, input instr_t x);
      dec_unit[s]    = {4'd0, x.unit};
      dec_op[s]      = x.op;
      dec_rs1[s]     = x.rs1;
      dec_rs2[s]     = x.rs2;
      dec_rs_use[s]  = x.rsu;
      dec_rd[s]      = x.rd;
      dec_rd_we[s]   = x.we;
      dec_payload[s] = PTAG | {58'd0, x.op};
   endtask

   task automatic apply(input vec_t t);
      dec_valid = t.dv;
      set_slot(0, t.i0);
      set_slot(1, t.i1);
      iss_ready = t.rdy;
      wb_valid  = t.wbv;
      wb_rd[0]  = t.wbrd;
      wb_rd[1]  = t.wbrd;
      flush     = t.fl;
   endtask

   task automatic check_vec(input int n, input vec_t t);
      chk($sformatf("v%0d dec_ready", n), 64'(dec_ready), 64'(t.e_drdy));
      chk($sformatf("v%0d iss_valid", n), 64'(iss_valid), 64'(t.e_vld));
      chk($sformatf("v%0d sb_stall", n), 64'(sb_stall), 64'(t.e_stall));
      chk($sformatf("v%0d empty", n), 64'(queue_empty), 64'(t.e_empty));
      for (int u = 0; u < 4; u++) begin
         if (t.e_vld[u]) begin
            chk($sformatf("v%0d op[%0d]", n, u), 64'(iss_op[u]), 64'(t.e_op[u]));
            chk($sformatf("v%0d payload[%0d]", n, u), iss_payload[u], PTAG | {58'd0, t.e_op[u]});
         end
      end
   endtask

   initial begin
      instr_t N;
      vec_t   z;
      N = '0;
      // Scenario table: each row is driven for one cycle and checked before its closing edge.
      tv.push_back(V(2'b11, I(0,1,0,0,0,1,1), I(3,2,0,0,0,2,1),  4'hF, 0, 0, 0, 1, 4'b0000, 0, 1, E(0,0,0,0)));
      tv.push_back(V(2'b00, N, N,                                4'hF, 0, 0, 0, 1, 4'b1001, 0, 0, E(2,0,0,1)));
      tv.push_back(V(2'b01, I(1,3,1,0,1,6,1), N,                 4'hF, 0, 0, 0, 1, 4'b0000, 0, 1, E(0,0,0,0)));
      tv.push_back(V(2'b00, N, N,                                4'hF, 1, 1, 0, 1, 4'b0000, 1, 0, E(0,0,0,0)));
      tv.push_back(V(2'b00, N, N,                                4'hF, 1, 2, 0, 1, 4'b0010, 0, 0, E(0,0,3,0)));
      tv.push_back(V(2'b11, I(0,4,0,0,0,5,1), I(1,5,5,0,1,7,1),  4'hF, 0, 0, 0, 1, 4'b0000, 0, 1, E(0,0,0,0)));
      tv.push_back(V(2'b00, N, N,                                4'hF, 0, 0, 0, 1, 4'b0001, 0, 0, E(0,0,0,4)));
      tv.push_back(V(2'b00, N, N,                                4'hF, 0, 0, 0, 1, 4'b0000, 1, 0, E(0,0,0,0)));
      tv.push_back(V(2'b00, N, N,                                4'hF, 2, 5, 0, 1, 4'b0000, 1, 0, E(0,0,0,0)));
      tv.push_back(V(2'b00, N, N,                                4'hF, 1, 7, 0, 1, 4'b0010, 0, 0, E(0,0,5,0)));
      tv.push_back(V(2'b01, I(0,6,7,0,1,0,1), N,                 4'hF, 0, 0, 0, 1, 4'b0000, 0, 1, E(0,0,0,0)));
      tv.push_back(V(2'b00, N, N,                                4'hF, 0, 0, 0, 1, 4'b0000, 1, 0, E(0,0,0,0)));
      tv.push_back(V(2'b00, N, N,                                4'hF, 1, 7, 0, 1, 4'b0000, 1, 0, E(0,0,0,0)));
      tv.push_back(V(2'b00, N, N,                                4'hF, 0, 0, 0, 1, 4'b0001, 0, 0, E(0,0,0,6)));
      tv.push_back(V(2'b11, I(0,7,0,0,0,8,1), I(0,8,0,0,0,9,1),  4'hF, 0, 0, 0, 1, 4'b0000, 0, 1, E(0,0,0,0)));
      tv.push_back(V(2'b00, N, N,                                4'hF, 0, 0, 0, 1, 4'b0001, 0, 0, E(0,0,0,7)));
      tv.push_back(V(2'b00, N, N,                                4'hF, 0, 0, 0, 1, 4'b0001, 0, 0, E(0,0,0,8)));
      tv.push_back(V(2'b11, I(0,9,0,0,0,10,1), I(3,10,0,0,0,11,1), 4'hF, 0, 0, 0, 1, 4'b0000, 0, 1, E(0,0,0,0)));
      for (int k = 0; k < 3; k++)
         tv.push_back(V(2'b00, N, N,                             4'hE, 0, 0, 0, 1, 4'b0001, 0, 0, E(0,0,0,9)));
      tv.push_back(V(2'b00, N, N,                                4'hF, 0, 0, 0, 1, 4'b1001, 0, 0, E(10,0,0,9)));
      tv.push_back(V(2'b11, I(0,11,10,0,1,12,1), I(0,12,0,0,0,13,1), 4'hF, 0, 0, 0, 1, 4'b0000, 0, 1, E(0,0,0,0)));
      tv.push_back(V(2'b11, I(0,13,0,0,0,14,1), I(0,14,0,0,0,15,1), 4'hF, 0, 0, 0, 1, 4'b0000, 1, 0, E(0,0,0,0)));
      tv.push_back(V(2'b11, I(0,40,0,0,0,16,1), I(0,41,0,0,0,17,1), 4'hF, 0, 0, 1, 0, 4'b0000, 0, 0, E(0,0,0,0)));
      tv.push_back(V(2'b01, I(0,15,10,0,1,16,1), N,              4'hF, 0, 0, 0, 1, 4'b0000, 0, 1, E(0,0,0,0)));
      tv.push_back(V(2'b00, N, N,                                4'hF, 2, 10, 0, 1, 4'b0000, 1, 0, E(0,0,0,0)));
      tv.push_back(V(2'b00, N, N,                                4'hF, 0, 0, 0, 1, 4'b0001, 0, 0, E(0,0,0,15)));
      tv.push_back(V(2'b11, I(0,16,0,0,0,20,1), I(1,17,0,20,2,21,1), 4'hF, 0, 0, 0, 1, 4'b0000, 0, 1, E(0,0,0,0)));
      tv.push_back(V(2'b00, N, N,                                4'hF, 0, 0, 0, 1, 4'b0001, 0, 0, E(0,0,0,16)));
      tv.push_back(V(2'b00, N, N,                                4'hF, 0, 0, 0, 1, 4'b0000, 1, 0, E(0,0,0,0)));
      tv.push_back(V(2'b00, N, N,                                4'hF, 1, 20, 0, 1, 4'b0000, 1, 0, E(0,0,0,0)));
      tv.push_back(V(2'b00, N, N,                                4'hF, 0, 0, 0, 1, 4'b0010, 0, 0, E(0,0,17,0)));
      tv.push_back(V(2'b01, I(2,18,0,0,0,21,1), N,               4'hF, 0, 0, 0, 1, 4'b0000, 0, 1, E(0,0,0,0)));
      tv.push_back(V(2'b00, N, N,                                4'hF, 1, 21, 0, 1, 4'b0000, 1, 0, E(0,0,0,0)));
      tv.push_back(V(2'b00, N, N,                                4'hF, 0, 0, 0, 1, 4'b0100, 0, 0, E(0,18,0,0)));
      tv.push_back(V(2'b00, N, N,                                4'hF, 0, 0, 0, 1, 4'b0000, 0, 1, E(0,0,0,0)));

      reset_n = 1'b0;
      z = V(2'b11, I(0,1,0,0,0,1,1), I(3,2,0,0,0,2,1), 4'hF, 0, 0, 0, 0, 4'b0000, 0, 0, E(0,0,0,0));
      apply(z);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("reset dec_ready", 64'(dec_ready), 64'd0);
         chk("reset iss_valid", 64'(iss_valid), 64'd0);
         chk("reset sb_stall", 64'(sb_stall), 64'd0);
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
      chk("reset empty", 64'(queue_empty), 64'd1);

      foreach (tv[n]) begin
         if (n > 0) begin
            @(posedge clk); #1;
         end
         apply(tv[n]);
         @(negedge clk);
         check_vec(n, tv[n]);
      end

      // Fill to 7 with every unit stalled, then drain through the ALU; three rounds wrap the pointers.
      for (int r = 0; r < 3; r++) begin
         int base;
         base = 20 + r * 8;
         for (int p = 0; p < 4; p++) begin
            @(posedge clk); #1;
            z = V((p < 3) ? 2'b11 : 2'b01, I(0, 6'(base + 2*p), 0,0,0,0,0),
                  I(0, 6'(base + 2*p + 1), 0,0,0,0,0), 4'h0, 0, 0, 0, 0, 4'b0, 0, 0, E(0,0,0,0));
            apply(z);
            @(negedge clk);
            chk($sformatf("fill r%0d p%0d dec_ready", r, p), 64'(dec_ready), 64'd1);
         end
         @(posedge clk); #1;
         z = V(2'b00, N, N, 4'h0, 0, 0, 0, 0, 4'b0, 0, 0, E(0,0,0,0));
         apply(z);
         @(negedge clk);
         chk($sformatf("full r%0d dec_ready", r), 64'(dec_ready), 64'd0);
         chk($sformatf("full r%0d iss_valid", r), 64'(iss_valid), 64'b0001);
         chk($sformatf("full r%0d op", r), 64'(iss_op[0]), 64'(base));
         for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            iss_ready = 4'b0001;
            @(negedge clk);
            chk($sformatf("drain r%0d k%0d iss_valid", r, k), 64'(iss_valid), 64'b0001);
            chk($sformatf("drain r%0d k%0d op", r, k), 64'(iss_op[0]), 64'(base + k));
         end
         @(posedge clk); #1;
         @(negedge clk);
         chk($sformatf("drain r%0d empty", r), 64'(queue_empty), 64'd1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
